// File: rtl/stream_buffer_ctrl_pkg.sv
// Shared types and constants for the stream buffer prefetch controller.
// The optional 4 KiB page guard is enabled with the SB_CTRL_PAGE_GUARD_EN macro.
package stream_buffer_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_HIT,
        S_ISSUE
    } sb_ctrl_state_t;

    localparam int unsigned SB_PAGE_BYTES = 4096;

    // Width of a line label (tag + index) for a 32-bit byte address.
    function automatic int unsigned sb_label_width(input int unsigned line_width);
        return 32 - $clog2(line_width / 8);
    endfunction

    // Number of low label bits that select a line inside one page.
    function automatic int unsigned sb_page_label_bits(input int unsigned line_width);
        return $clog2(SB_PAGE_BYTES) - $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/stream_buffer_ctrl_if.sv
// Bundle of the cache-miss handshake and the stream buffer label/inv/data
// signals. The controller uses the slave modport; the cache/buffer side
// uses the master modport.
interface stream_buffer_ctrl_if
    import stream_buffer_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int LABEL_WIDTH = int'(sb_label_width(LINE_WIDTH))
);
    // Cache miss path
    logic [LABEL_WIDTH-1:0] req_label;
    logic                   req_vld;
    logic                   req_rdy;
    logic                   resp_vld;
    logic                   resp_hit;
    logic [LINE_WIDTH-1:0]  resp_data;
    logic                   flush;

    // Stream buffer side
    logic [LABEL_WIDTH-1:0] sb_label_i;
    logic                   sb_label_i_rdy;
    logic                   sb_inv;
    logic [LABEL_WIDTH-1:0] sb_label_o;
    logic                   sb_label_o_vld;
    logic [LINE_WIDTH-1:0]  sb_data;
    logic                   sb_data_vld;

    modport slave (
        input  req_label, req_vld, flush,
        input  sb_label_o, sb_label_o_vld, sb_data, sb_data_vld,
        output req_rdy, resp_vld, resp_hit, resp_data,
        output sb_label_i, sb_label_i_rdy, sb_inv
    );

    modport master (
        output req_label, req_vld, flush,
        output sb_label_o, sb_label_o_vld, sb_data, sb_data_vld,
        input  req_rdy, resp_vld, resp_hit, resp_data,
        input  sb_label_i, sb_label_i_rdy, sb_inv
    );

endinterface

// File: rtl/stream_buffer_ctrl.sv
// Stream buffer prefetch sequencer: looks up each cache miss in the stream
// buffer, returns the line on a hit, then re-targets the buffer to the next
// sequential line (invalidating it on a miss).
// Optional: define SB_CTRL_PAGE_GUARD_EN to suppress prefetch across a
// 4 KiB page boundary.
module stream_buffer_ctrl
    import stream_buffer_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH = 256
) (
    input  logic                clk,
    input  logic                rst,   // asynchronous, active-low
    stream_buffer_ctrl_if.slave bus
);

    localparam int LABEL_WIDTH = int'(sb_label_width(LINE_WIDTH));

    typedef logic [LABEL_WIDTH-1:0] label_t;

    sb_ctrl_state_t        state_q, state_d;
    label_t                lbl_q, lbl_d;     // label of the request in service
    label_t                tgt_q, tgt_d;     // prefetch target driven to the buffer
    logic                  resp_vld_q, resp_vld_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;

    logic   req_rdy_c;
    logic   accept;
    logic   lbl_match;
    logic   tgt_match;
    logic   inv_c;
    logic   issue_c;
    logic   prefetch_ok;
    label_t lbl_inc;

    // Next sequential line; all-ones wraps to zero naturally.
    assign lbl_inc = lbl_q + label_t'(1);

`ifdef SB_CTRL_PAGE_GUARD_EN
    localparam int PAGE_BITS = int'(sb_page_label_bits(LINE_WIDTH));
    // A next line at page offset zero lives in a different page: no prefetch.
    assign prefetch_ok = (lbl_inc[PAGE_BITS-1:0] != '0);
`else
    assign prefetch_ok = 1'b1;
`endif

    // Requests are taken only when idle or re-targeting; flush blocks them,
    // and nothing is offered while reset is held.
    assign req_rdy_c = rst && !bus.flush && (state_q == S_IDLE || state_q == S_ISSUE);
    assign accept    = bus.req_vld && req_rdy_c;
    assign lbl_match = bus.sb_label_o_vld && (bus.sb_label_o == lbl_q);
    assign tgt_match = bus.sb_label_o_vld && (bus.sb_label_o == tgt_q);

    // Next-state, response and buffer-control decode; flush overrides all.
    always_comb begin
        state_d     = state_q;
        lbl_d       = lbl_q;
        tgt_d       = tgt_q;
        resp_vld_d  = 1'b0;
        resp_hit_d  = resp_hit_q;
        resp_data_d = resp_data_q;
        inv_c       = 1'b0;
        issue_c     = 1'b0;

        if (bus.flush) begin
            inv_c   = 1'b1;
            state_d = S_IDLE;
            // An outstanding request still owes the cache exactly one answer.
            if (state_q == S_LOOKUP || state_q == S_WAIT_HIT) begin
                resp_vld_d = 1'b1;
                resp_hit_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        lbl_d   = bus.req_label;
                        state_d = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lbl_match && bus.sb_data_vld) begin
                        resp_vld_d  = 1'b1;
                        resp_hit_d  = 1'b1;
                        resp_data_d = bus.sb_data;
                        tgt_d       = lbl_inc;
                        state_d     = prefetch_ok ? S_ISSUE : S_IDLE;
                    end else if (lbl_match) begin
                        state_d = S_WAIT_HIT;
                    end else begin
                        // Buffer holds an unrelated stream: drop it and restart.
                        resp_vld_d = 1'b1;
                        resp_hit_d = 1'b0;
                        inv_c      = 1'b1;
                        tgt_d      = lbl_inc;
                        state_d    = prefetch_ok ? S_ISSUE : S_IDLE;
                    end
                end
                S_WAIT_HIT: begin
                    if (lbl_match && bus.sb_data_vld) begin
                        resp_vld_d  = 1'b1;
                        resp_hit_d  = 1'b1;
                        resp_data_d = bus.sb_data;
                        tgt_d       = lbl_inc;
                        state_d     = prefetch_ok ? S_ISSUE : S_IDLE;
                    end else if (!lbl_match) begin
                        // Buffer lost the line mid-fetch; let the cache fill it.
                        resp_vld_d = 1'b1;
                        resp_hit_d = 1'b0;
                        tgt_d      = lbl_inc;
                        state_d    = prefetch_ok ? S_ISSUE : S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        lbl_d   = bus.req_label;
                        state_d = S_LOOKUP;
                    end else begin
                        // Hold the target until the buffer reports it as its label.
                        issue_c = 1'b1;
                        if (tgt_match) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lbl_q       <= '0;
            tgt_q       <= '0;
            resp_vld_q  <= 1'b0;
            resp_hit_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lbl_q       <= lbl_d;
            tgt_q       <= tgt_d;
            resp_vld_q  <= resp_vld_d;
            resp_hit_q  <= resp_hit_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.req_rdy        = req_rdy_c;
    assign bus.resp_vld       = resp_vld_q;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.sb_label_i     = tgt_q;
    assign bus.sb_label_i_rdy = issue_c;
    assign bus.sb_inv         = rst && inv_c;

endmodule

// File: tb/tb_stream_buffer_ctrl.sv
// Self-checking bench for stream_buffer_ctrl (LINE_WIDTH=256, LABEL_WIDTH=27).
// Honours SB_CTRL_PAGE_GUARD_EN when compiled with it.
module tb_stream_buffer_ctrl;

    localparam int LW  = 256;
    localparam int LBW = 27;

    localparam int K_MISS   = 0;
    localparam int K_RES    = 1;
    localparam int K_FLIGHT = 2;
    localparam int K_FLUSHW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_buffer_ctrl_if #(.LINE_WIDTH(LW)) bus ();

    stream_buffer_ctrl #(.LINE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next line label, modulo 2^LBW.
    function automatic logic [LBW-1:0] next_line(input logic [LBW-1:0] l);
        longint v;
        v = (longint'(l) + 1) % (longint'(1) << LBW);
        return LBW'(v);
    endfunction

    // Whether the controller is expected to prefetch the given next line.
    function automatic bit prefetch_allowed(input logic [LBW-1:0] nl);
`ifdef SB_CTRL_PAGE_GUARD_EN
        return ((longint'(nl) * (LW / 8)) % 4096) != 0;
`else
        return (nl == nl);
`endif
    endfunction

    // One complete miss transaction, with the bench acting as the stream buffer.
    task automatic run_txn(input string tag, input logic [LBW-1:0] lbl, input int kind,
                           input int dly, input bit finish_issue);
        logic [LW-1:0]  d;
        logic [LBW-1:0] tgt;
        bit             exp_hit;
        bit             exp_issue;
        int             hold;
        d         = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tgt       = next_line(lbl);
        exp_hit   = (kind == K_RES) || (kind == K_FLIGHT);
        exp_issue = (kind != K_FLUSHW) && prefetch_allowed(tgt);

        @(negedge clk);
        bus.sb_data        = d;
        bus.sb_data_vld    = 1'b0;
        bus.sb_label_o_vld = 1'b1;
        bus.sb_label_o     = lbl;
        if (kind == K_MISS) begin
            bus.sb_label_o_vld = 1'($urandom_range(0, 1));
            bus.sb_label_o     = LBW'((longint'(lbl) + longint'($urandom_range(2, 1000))) % (longint'(1) << LBW));
            bus.sb_data_vld    = 1'($urandom_range(0, 1));
        end else if (kind == K_RES) begin
            bus.sb_data_vld = 1'b1;
        end
        bus.req_label = lbl;
        bus.req_vld   = 1'b1;
        #1 chk($sformatf("%s.req_rdy_accept", tag), bus.req_rdy, 1);

        @(negedge clk);
        bus.req_vld   = 1'b0;
        bus.req_label = LBW'($urandom);
        #1;
        chk($sformatf("%s.inv_lookup", tag), bus.sb_inv, (kind == K_MISS));
        chk($sformatf("%s.resp_early", tag), bus.resp_vld, 0);
        chk($sformatf("%s.rdy_lookup", tag), bus.sb_label_i_rdy, 0);

        if (kind == K_FLIGHT || kind == K_FLUSHW) begin
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                #1 chk($sformatf("%s.resp_wait", tag), bus.resp_vld, 0);
            end
            if (kind == K_FLIGHT) begin
                bus.sb_data_vld = 1'b1;
            end else begin
                @(negedge clk);
                bus.flush = 1'b1;
                #1;
                chk($sformatf("%s.flush_inv", tag), bus.sb_inv, 1);
                chk($sformatf("%s.flush_rdy", tag), bus.sb_label_i_rdy, 0);
                chk($sformatf("%s.flush_req_rdy", tag), bus.req_rdy, 0);
            end
        end

        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk($sformatf("%s.resp_vld", tag), bus.resp_vld, 1);
        chk($sformatf("%s.resp_hit", tag), bus.resp_hit, exp_hit);
        if (exp_hit) chk($sformatf("%s.resp_data", tag), bus.resp_data, d);
        chk($sformatf("%s.inv_resp", tag), bus.sb_inv, 0);
        chk($sformatf("%s.issue", tag), bus.sb_label_i_rdy, exp_issue);
        if (exp_issue) chk($sformatf("%s.target", tag), bus.sb_label_i, tgt);
        bus.sb_data_vld    = 1'b0;
        bus.sb_label_o_vld = 1'b0;

        @(negedge clk);
        #1;
        chk($sformatf("%s.single_resp", tag), bus.resp_vld, 0);
        chk($sformatf("%s.issue_held", tag), bus.sb_label_i_rdy, exp_issue);
        if (!exp_issue) chk($sformatf("%s.idle_req_rdy", tag), bus.req_rdy, 1);

        if (exp_issue && finish_issue) begin
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                chk($sformatf("%s.issue_hold", tag), bus.sb_label_i_rdy, 1);
                chk($sformatf("%s.target_hold", tag), bus.sb_label_i, tgt);
            end
            bus.sb_label_o     = tgt;
            bus.sb_label_o_vld = 1'b1;
            #1 chk($sformatf("%s.issue_last", tag), bus.sb_label_i_rdy, 1);
            @(negedge clk);
            #1;
            chk($sformatf("%s.issue_done", tag), bus.sb_label_i_rdy, 0);
            chk($sformatf("%s.req_rdy_done", tag), bus.req_rdy, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_label      = '0;
        bus.req_vld        = 1'b0;
        bus.flush          = 1'b0;
        bus.sb_label_o     = '0;
        bus.sb_label_o_vld = 1'b0;
        bus.sb_data        = '0;
        bus.sb_data_vld    = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        chk("rst.resp_vld", bus.resp_vld, 0);
        chk("rst.resp_hit", bus.resp_hit, 0);
        chk("rst.resp_data", bus.resp_data, 0);
        chk("rst.sb_inv", bus.sb_inv, 0);
        chk("rst.label_i_rdy", bus.sb_label_i_rdy, 0);
        chk("rst.label_i", bus.sb_label_i, 0);
        chk("rst.req_rdy", bus.req_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst.req_rdy_release", bus.req_rdy, 1);

        // Directed scenarios
        run_txn("cold_miss", 27'h100, K_MISS, 0, 1);
        run_txn("resident_hit", 27'h101, K_RES, 0, 1);
        run_txn("inflight_hit", 27'h102, K_FLIGHT, 6, 1);
        run_txn("flush_wait", 27'h200, K_FLUSHW, 1, 1);
        run_txn("wrap", 27'h7FFFFFF, K_MISS, 0, 1);
        run_txn("page_edge", 27'h07F, K_MISS, 0, 1);
        run_txn("page_edge_hit", 27'h0FF, K_RES, 0, 1);

        // Flush coincident with a request: flush wins, request not taken
        @(negedge clk);
        bus.req_vld   = 1'b1;
        bus.req_label = 27'h123;
        bus.flush     = 1'b1;
        #1;
        chk("flush_acc.req_rdy", bus.req_rdy, 0);
        chk("flush_acc.inv", bus.sb_inv, 1);
        chk("flush_acc.label_i_rdy", bus.sb_label_i_rdy, 0);
        @(negedge clk);
        bus.req_vld = 1'b0;
        bus.flush   = 1'b0;
        #1;
        chk("flush_acc.not_taken", bus.req_rdy, 1);
        chk("flush_acc.inv_clear", bus.sb_inv, 0);
        @(negedge clk);
        #1 chk("flush_acc.no_resp", bus.resp_vld, 0);

        // Asynchronous reset while re-targeting the buffer
        run_txn("rst_issue", 27'h300, K_MISS, 0, 0);
        chk("rst_issue.in_issue", bus.sb_label_i_rdy, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_issue.label_i_rdy", bus.sb_label_i_rdy, 0);
        chk("rst_issue.label_i", bus.sb_label_i, 0);
        chk("rst_issue.resp_vld", bus.resp_vld, 0);
        chk("rst_issue.resp_hit", bus.resp_hit, 0);
        chk("rst_issue.resp_data", bus.resp_data, 0);
        chk("rst_issue.sb_inv", bus.sb_inv, 0);
        chk("rst_issue.req_rdy", bus.req_rdy, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_issue.req_rdy_release", bus.req_rdy, 1);
        chk("rst_issue.idle", bus.sb_label_i_rdy, 0);

        // Randomised transactions
        for (int n = 0; n < 40; n++) begin
            logic [LBW-1:0] lbl;
            int kind;
            int dly;
            lbl  = LBW'($urandom);
            kind = $urandom_range(0, 3);
            dly  = (kind == K_FLUSHW) ? $urandom_range(0, 3) : $urandom_range(1, 6);
            run_txn($sformatf("rnd%0d", n), lbl, kind, dly, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
